// File: rtl/bht_sched_pkg.sv
// Shared types and default widths for the BHT update scheduler.
// Entries are packed {index, tag, taken}, with taken in the LSB.
package bht_sched_pkg;

    localparam int INDEX_LEN_DEF = 7;
    localparam int TAG_LEN_DEF   = 7;
    localparam int ENTRY_W       = INDEX_LEN_DEF + TAG_LEN_DEF + 1;
    localparam int COUNT_LEN     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALLOC  = 2'd1,
        UPDATE = 2'd2
    } state_t;

endpackage

// File: rtl/bht_update_fifo.sv
// Circular update queue; every slot is exposed flat, with a valid mask, for lookups.
// Latency: a push is visible at the head one cycle later; head and next are read combinationally.
// Backpressure: a push while full is ignored, and flush overrides push. Flush with keep_head retains only the head.
module bht_update_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     flush_keep_head,
    output logic [W-1:0]             head_dat,
    output logic [W-1:0]             next_dat,
    output logic [DEPTH*W-1:0]       entries_flat,
    output logic [DEPTH-1:0]         entries_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] off;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_q];
    assign next_dat = mem_q[rd_q + PW'(1)];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            // Keeping the head leaves exactly one entry, unless that entry is popped on this same edge.
            if (flush_keep_head && !empty) begin
                rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
                wr_d    = rd_q + PW'(1);
                count_d = do_pop ? '0 : CW'(1);
            end else begin
                wr_d    = rd_q;
                count_d = '0;
            end
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_dat;
                wr_d        = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        off          = '0;
        entries_vld  = '0;
        entries_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off                    = PW'(i) - rd_q;
            entries_vld[i]         = ({1'b0, off} < count_q);
            entries_flat[i*W +: W] = mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bht_update_scheduler.sv
// Queues resolved branches and issues each one to the BHT write port as an ALLOC cycle followed by an UPDATE cycle.
// Latency: a push at edge t appears as ALLOC after t+1 and UPDATE after t+2; throughput is one update every 2 cycles.
// Backpressure: upd_ready is !full and does not account for a same-cycle pop. Offers made during flush are dropped.
module bht_update_scheduler
    import bht_sched_pkg::*;
#(
    parameter int INDEX_LEN = INDEX_LEN_DEF,
    parameter int TAG_LEN   = TAG_LEN_DEF,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [INDEX_LEN-1:0]     upd_index,
    input  logic [TAG_LEN-1:0]       upd_tag,
    input  logic                     upd_taken,
    input  logic                     flush,
    input  logic [INDEX_LEN-1:0]     rd_index,
    input  logic [TAG_LEN-1:0]       rd_tag,
    output logic                     rd_stale,
    output logic [INDEX_LEN-1:0]     bht_index_write,
    output logic [TAG_LEN-1:0]       bht_tag_write,
    output logic                     bht_increment_decrement,
    output logic                     bht_write_enabled,
    output logic                     bht_write_active,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     busy
);

    localparam int EW = INDEX_LEN + TAG_LEN + 1;
    localparam int KW = INDEX_LEN + TAG_LEN;
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                 state_q, state_d;
    logic [INDEX_LEN-1:0]   idx_q, idx_d;
    logic [TAG_LEN-1:0]     tag_q, tag_d;
    logic                   dir_q, dir_d;
    logic                   we_q, we_d;
    logic                   act_q, act_d;

    logic                   push, pop, keep_head, load, full, empty;
    logic [EW-1:0]          upd_dat, head_dat, next_dat, load_dat;
    logic [DEPTH*EW-1:0]    entries_flat;
    logic [DEPTH-1:0]       entries_vld;
    logic [CW-1:0]          count;
    logic                   unused_taken;

    assign upd_dat   = {upd_index, upd_tag, upd_taken};
    assign push      = upd_valid && !full && !flush;
    assign upd_ready = !full;
    assign occupancy = count;
    assign busy      = (state_q != IDLE) || !empty;

    bht_update_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .push_dat        (upd_dat),
        .pop             (pop),
        .flush           (flush),
        .flush_keep_head (keep_head),
        .head_dat        (head_dat),
        .next_dat        (next_dat),
        .entries_flat    (entries_flat),
        .entries_vld     (entries_vld),
        .count           (count),
        .full            (full),
        .empty           (empty)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tag_d     = tag_q;
        dir_d     = dir_q;
        we_d      = we_q;
        act_d     = act_q;
        pop       = 1'b0;
        keep_head = 1'b0;
        load      = 1'b0;
        load_dat  = head_dat;
        case (state_q)
            IDLE: begin
                if (!flush && !empty) begin
                    state_d = ALLOC;
                    load    = 1'b1;
                end
            end
            ALLOC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = UPDATE;
                    we_d    = 1'b1;
                end
            end
            UPDATE: begin
                pop = 1'b1;
                if (flush) begin
                    keep_head = 1'b1;
                    state_d   = IDLE;
                end else if (count > CW'(1) || push) begin
                    // With only the head left, the successor is whatever is pushed on this same edge.
                    state_d  = ALLOC;
                    load     = 1'b1;
                    load_dat = (count > CW'(1)) ? next_dat : upd_dat;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            {idx_d, tag_d, dir_d} = load_dat;
            act_d = 1'b1;
            we_d  = 1'b0;
        end else if (state_d == IDLE) begin
            idx_d = '0;
            tag_d = '0;
            dir_d = 1'b0;
            we_d  = 1'b0;
            act_d = 1'b0;
        end
    end

    always_comb begin
        rd_stale     = 1'b0;
        unused_taken = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_vld[i] && entries_flat[i*EW+1 +: KW] == {rd_index, rd_tag}) begin
                rd_stale = 1'b1;
            end
            unused_taken = unused_taken ^ entries_flat[i*EW];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tag_q   <= '0;
            dir_q   <= 1'b0;
            we_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tag_q   <= tag_d;
            dir_q   <= dir_d;
            we_q    <= we_d;
            act_q   <= act_d;
        end
    end

    assign bht_index_write         = idx_q;
    assign bht_tag_write           = tag_q;
    assign bht_increment_decrement = dir_q;
    assign bht_write_enabled       = we_q;
    assign bht_write_active        = act_q;

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Directed bench for bht_update_scheduler; every expected value is derived by hand from the intended cycle timing.
module tb_bht_update_scheduler;

    logic       clk;
    logic       reset;
    logic       upd_valid;
    logic       upd_ready;
    logic [6:0] upd_index;
    logic [6:0] upd_tag;
    logic       upd_taken;
    logic       flush;
    logic [6:0] rd_index;
    logic [6:0] rd_tag;
    logic       rd_stale;
    logic [6:0] bht_index_write;
    logic [6:0] bht_tag_write;
    logic       bht_increment_decrement;
    logic       bht_write_enabled;
    logic       bht_write_active;
    logic [2:0] occupancy;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    bht_update_scheduler #(
        .INDEX_LEN (7),
        .TAG_LEN   (7),
        .DEPTH     (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .upd_valid               (upd_valid),
        .upd_ready               (upd_ready),
        .upd_index               (upd_index),
        .upd_tag                 (upd_tag),
        .upd_taken               (upd_taken),
        .flush                   (flush),
        .rd_index                (rd_index),
        .rd_tag                  (rd_tag),
        .rd_stale                (rd_stale),
        .bht_index_write         (bht_index_write),
        .bht_tag_write           (bht_tag_write),
        .bht_increment_decrement (bht_increment_decrement),
        .bht_write_enabled       (bht_write_enabled),
        .bht_write_active        (bht_write_active),
        .occupancy               (occupancy),
        .busy                    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [6:0] idx, input logic [6:0] tg, input logic tk);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_tag   = tg;
        upd_taken = tk;
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0;
        upd_index = '0;
        upd_tag   = '0;
        upd_taken = 1'b0;
    endtask

    int  occ_exp [14];
    int  k;
    int  e;
    logic acc;
    logic exp_act;

    initial begin
        occ_exp = '{1, 2, 3, 3, 4, 3, 4, 3, 3, 2, 2, 1, 1, 0};
        reset    = 1'b0;
        flush    = 1'b0;
        rd_index = '0;
        rd_tag   = '0;
        idle_inputs();
        repeat (2) tick();

        chk("rst_act",   32'(bht_write_active), 32'd0);
        chk("rst_we",    32'(bht_write_enabled), 32'd0);
        chk("rst_idx",   32'(bht_index_write), 32'd0);
        chk("rst_occ",   32'(occupancy), 32'd0);
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        // Single update: ALLOC, then UPDATE, then idle.
        offer(7'd5, 7'h12, 1'b1);
        tick();
        idle_inputs();
        chk("t1_push_occ", 32'(occupancy), 32'd1);
        chk("t1_push_act", 32'(bht_write_active), 32'd0);
        chk("t1_push_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_alloc_act", 32'(bht_write_active), 32'd1);
        chk("t1_alloc_we",  32'(bht_write_enabled), 32'd0);
        chk("t1_alloc_idx", 32'(bht_index_write), 32'd5);
        chk("t1_alloc_tag", 32'(bht_tag_write), 32'h12);
        chk("t1_alloc_dir", 32'(bht_increment_decrement), 32'd1);
        tick();
        chk("t1_upd_act", 32'(bht_write_active), 32'd1);
        chk("t1_upd_we",  32'(bht_write_enabled), 32'd1);
        chk("t1_upd_idx", 32'(bht_index_write), 32'd5);
        chk("t1_upd_tag", 32'(bht_tag_write), 32'h12);
        tick();
        chk("t1_idle_act", 32'(bht_write_active), 32'd0);
        chk("t1_idle_we",  32'(bht_write_enabled), 32'd0);
        chk("t1_idle_occ", 32'(occupancy), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Six entries offered back-to-back; the queue fills and stalls the sixth until a pop.
        k = 0;
        offer(7'd10, 7'h20, 1'b0);
        for (int n = 1; n <= 14; n++) begin
            acc = upd_valid && upd_ready;
            tick();
            if (acc) begin
                k++;
                if (k == 6) idle_inputs();
                else offer(7'(10 + k), 7'(32 + k), k[0]);
            end
            exp_act = (n >= 2) && (n <= 13);
            e = (n - 2) / 2;
            chk("t2_occ",   32'(occupancy), 32'(occ_exp[n-1]));
            chk("t2_ready", 32'(upd_ready), (occ_exp[n-1] == 4) ? 32'd0 : 32'd1);
            chk("t2_act",   32'(bht_write_active), 32'(exp_act));
            chk("t2_we",    32'(bht_write_enabled), 32'(exp_act && (n % 2 == 1)));
            chk("t2_idx",   32'(bht_index_write), exp_act ? 32'(10 + e) : 32'd0);
            chk("t2_tag",   32'(bht_tag_write), exp_act ? 32'(32 + e) : 32'd0);
            chk("t2_dir",   32'(bht_increment_decrement), exp_act ? 32'(e % 2) : 32'd0);
        end
        chk("t2_accepted", 32'(k), 32'd6);
        chk("t2_busy", 32'(busy), 32'd0);

        // Lookup staleness against a queued and then an in-flight entry.
        offer(7'd3, 7'h07, 1'b0);
        tick();
        idle_inputs();
        rd_index = 7'd3;
        rd_tag   = 7'h07;
        #1 chk("t3_stale_hit", 32'(rd_stale), 32'd1);
        rd_tag = 7'h08;
        #1 chk("t3_stale_tag_miss", 32'(rd_stale), 32'd0);
        rd_index = 7'd4;
        rd_tag   = 7'h07;
        #1 chk("t3_stale_idx_miss", 32'(rd_stale), 32'd0);
        rd_index = 7'd3;
        tick();
        chk("t3_stale_alloc", 32'(rd_stale), 32'd1);
        tick();
        chk("t3_stale_update", 32'(rd_stale), 32'd1);
        chk("t3_upd_we", 32'(bht_write_enabled), 32'd1);
        tick();
        chk("t3_stale_done", 32'(rd_stale), 32'd0);
        chk("t3_done_act", 32'(bht_write_active), 32'd0);
        rd_index = '0;
        rd_tag   = '0;

        // Flush during UPDATE: the head commits and the rest are discarded.
        offer(7'd20, 7'h01, 1'b1);
        tick();
        offer(7'd21, 7'h02, 1'b0);
        tick();
        offer(7'd22, 7'h03, 1'b1);
        tick();
        idle_inputs();
        chk("t4_upd_we",  32'(bht_write_enabled), 32'd1);
        chk("t4_upd_idx", 32'(bht_index_write), 32'd20);
        chk("t4_upd_tag", 32'(bht_tag_write), 32'h01);
        chk("t4_upd_occ", 32'(occupancy), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_act", 32'(bht_write_active), 32'd0);
        chk("t4_flush_occ", 32'(occupancy), 32'd0);
        chk("t4_flush_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_no_alloc", 32'(bht_write_active), 32'd0);
        chk("t4_no_alloc_occ", 32'(occupancy), 32'd0);

        // Flush during ALLOC together with a push: nothing issues and the push is dropped.
        offer(7'd30, 7'h05, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("t5_alloc_act", 32'(bht_write_active), 32'd1);
        chk("t5_alloc_we",  32'(bht_write_enabled), 32'd0);
        chk("t5_alloc_idx", 32'(bht_index_write), 32'd30);
        flush = 1'b1;
        offer(7'd31, 7'h06, 1'b1);
        tick();
        flush = 1'b0;
        idle_inputs();
        chk("t5_flush_act", 32'(bht_write_active), 32'd0);
        chk("t5_flush_we",  32'(bht_write_enabled), 32'd0);
        chk("t5_flush_occ", 32'(occupancy), 32'd0);
        tick();
        chk("t5_no_update", 32'(bht_write_enabled), 32'd0);
        chk("t5_no_alloc", 32'(bht_write_active), 32'd0);
        chk("t5_final_occ", 32'(occupancy), 32'd0);

        // Reset asserted mid-UPDATE takes effect without waiting for a clock edge.
        offer(7'd40, 7'h09, 1'b1);
        tick();
        offer(7'd41, 7'h0a, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("t6_upd_we", 32'(bht_write_enabled), 32'd1);
        chk("t6_upd_occ", 32'(occupancy), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_act",   32'(bht_write_active), 32'd0);
        chk("t6_rst_we",    32'(bht_write_enabled), 32'd0);
        chk("t6_rst_idx",   32'(bht_index_write), 32'd0);
        chk("t6_rst_tag",   32'(bht_tag_write), 32'd0);
        chk("t6_rst_dir",   32'(bht_increment_decrement), 32'd0);
        chk("t6_rst_occ",   32'(occupancy), 32'd0);
        chk("t6_rst_ready", 32'(upd_ready), 32'd1);
        chk("t6_rst_busy",  32'(busy), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
